// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_if
// Brief    : SPI slave front end for the single-port RAM. Deserialises
//            {cmd[1:0], payload} MOSI frames into rx_data with a one-cycle
//            rx_valid strobe, and for read-data frames shifts the RAM read
//            word out on MISO. Runs directly on the SPI serial clock.
// Optional : SPI_FRAME_ERR_EN adds the frame_err output (abort indicator).
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_if #(
  parameter int ADDR_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [ADDR_SIZE+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [ADDR_SIZE-1:0] tx_data,
  input  logic                 tx_valid
`ifdef SPI_FRAME_ERR_EN
  ,
  output logic                 frame_err
`endif
);

  localparam int c_FRAME_BITS = ADDR_SIZE + 2;
  localparam int c_CNT_W      = $clog2(c_FRAME_BITS + 1);
  localparam int c_TXC_W      = $clog2(ADDR_SIZE);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_FRAME_BITS - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(c_FRAME_BITS);
  localparam logic [c_TXC_W-1:0] c_TX_LAST  = c_TXC_W'(ADDR_SIZE - 1);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CHK_CMD   = 3'd1,
    S_WRITE     = 3'd2,
    S_READ_ADD  = 3'd3,
    S_READ_DATA = 3'd4
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [c_CNT_W-1:0]      r_cnt;
  logic [c_FRAME_BITS-2:0] r_rx_shift;
  logic [ADDR_SIZE+1:0]    r_rx_data;
  logic                    r_rx_valid;
  logic                    r_rd_addr_seen;
  logic                    r_miso;
  logic                    r_tx_active;    // a MISO bit is currently on the wire
  logic                    r_tx_captured;  // read word already taken this frame
  logic [ADDR_SIZE-1:0]    r_tx_shift;
  logic [c_TXC_W-1:0]      r_tx_left;      // bits still to send after the current one

  logic w_busy;
  logic w_abort;
  logic w_sample;
  logic w_last_bit;
  logic w_capture;

  assign w_busy     = (r_state != S_IDLE);
  assign w_abort    = w_busy && SS_n;
  // The counter saturates at a full frame so trailing MOSI bits are ignored.
  assign w_sample   = w_busy && !SS_n && (r_cnt != c_CNT_FULL);
  assign w_last_bit = w_sample && (r_cnt == c_CNT_LAST);
  // Capture is held off during the rx_valid cycle so a tx_valid level left
  // high from earlier cannot grab the stale RAM word.
  assign w_capture  = (r_state == S_READ_DATA) && !SS_n && (r_cnt == c_CNT_FULL) &&
                      !r_rx_valid && !r_tx_captured && tx_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode; the first MOSI bit plus rd_addr_seen pick the path
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (!SS_n) w_state_nxt = S_CHK_CMD;
      end
      S_CHK_CMD: begin
        if (SS_n)                w_state_nxt = S_IDLE;
        else if (!MOSI)          w_state_nxt = S_WRITE;
        else if (r_rd_addr_seen) w_state_nxt = S_READ_DATA;
        else                     w_state_nxt = S_READ_ADD;
      end
      S_WRITE, S_READ_ADD, S_READ_DATA: begin
        if (SS_n) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift-in, shift-out and read-address tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt          <= '0;
      r_rx_shift     <= '0;
      r_rx_data      <= '0;
      r_rx_valid     <= 1'b0;
      r_rd_addr_seen <= 1'b0;
      r_miso         <= 1'b0;
      r_tx_active    <= 1'b0;
      r_tx_captured  <= 1'b0;
      r_tx_shift     <= '0;
      r_tx_left      <= '0;
    end else begin
      r_rx_valid <= 1'b0;
      if (w_abort) begin
        r_cnt         <= '0;
        r_miso        <= 1'b0;
        r_tx_active   <= 1'b0;
        r_tx_captured <= 1'b0;
        r_tx_left     <= '0;
        // Last bit already on the wire means the shift-out did complete.
        if (r_tx_active && (r_tx_left == '0)) r_rd_addr_seen <= 1'b0;
      end else begin
        if (w_sample) begin
          r_cnt      <= r_cnt + 1'b1;
          r_rx_shift <= {r_rx_shift[c_FRAME_BITS-3:0], MOSI};
          if (w_last_bit) begin
            r_rx_data  <= {r_rx_shift, MOSI};
            r_rx_valid <= 1'b1;
            if (r_state == S_READ_ADD) r_rd_addr_seen <= 1'b1;
          end
        end
        if (w_capture) begin
          r_tx_captured <= 1'b1;
          r_tx_active   <= 1'b1;
          r_miso        <= tx_data[ADDR_SIZE-1];
          r_tx_shift    <= {tx_data[ADDR_SIZE-2:0], 1'b0};
          r_tx_left     <= c_TX_LAST;
        end else if (r_tx_active) begin
          if (r_tx_left != '0) begin
            r_miso     <= r_tx_shift[ADDR_SIZE-1];
            r_tx_shift <= {r_tx_shift[ADDR_SIZE-2:0], 1'b0};
            r_tx_left  <= r_tx_left - 1'b1;
          end else begin
            r_miso         <= 1'b0;
            r_tx_active    <= 1'b0;
            r_rd_addr_seen <= 1'b0;
          end
        end
      end
    end
  end

  assign MISO     = r_miso;
  assign rx_data  = r_rx_data;
  assign rx_valid = r_rx_valid;

`ifdef SPI_FRAME_ERR_EN
  logic r_frame_err;
  logic w_tx_partial;

  assign w_tx_partial = r_tx_active && (r_tx_left != '0);

  // Flag a frame cut short mid shift-in or mid shift-out
  always_ff @(posedge clk) begin
    if (rst) begin
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_abort &&
                     (((r_cnt != '0) && (r_cnt != c_CNT_FULL)) || w_tx_partial);
    end
  end

  assign frame_err = r_frame_err;
`else
  // Without the error port an aborted frame is simply dropped.
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_if
// Brief    : Scoreboard bench for spi_slave_if with a 1-cycle RAM model.
//            Frame-level reference model predicts rx_valid/rx_data, MISO
//            bytes and (with SPI_FRAME_ERR_EN) frame_err pulses per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_if;

  localparam int ADDR_SIZE = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       SS_n;
  logic       MOSI;
  logic       MISO;
  logic [9:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_valid;
`ifdef SPI_FRAME_ERR_EN
  logic       frame_err;
`endif

  spi_slave_if #(.ADDR_SIZE(ADDR_SIZE)) dut (
    .clk      (clk),
    .rst      (rst),
    .SS_n     (SS_n),
    .MOSI     (MOSI),
    .MISO     (MISO),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid)
`ifdef SPI_FRAME_ERR_EN
    ,
    .frame_err(frame_err)
`endif
  );

  always #5 clk = ~clk;

  // Number of posedges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // -------------------------------------------------------------- RAM model
  logic [7:0] ram_mem [256];
  logic [7:0] ram_wa = '0;
  logic [7:0] ram_ra = '0;
  logic [7:0] ram_dout = '0;
  int         ram_cnt = 0;
  int         ram_delay = 0;
  bit         tv_sticky = 1'b0;

  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i) ^ 8'h5A;
    end
    if (ram_cnt != 0) ram_cnt <= ram_cnt - 1;
    if (rx_valid === 1'b1) begin
      case (rx_data[9:8])
        2'b00: ram_wa <= rx_data[7:0];
        2'b01: ram_mem[ram_wa] <= rx_data[7:0];
        2'b10: ram_ra <= rx_data[7:0];
        default: begin
          ram_dout <= ram_mem[ram_ra];
          ram_cnt  <= ram_delay + 1;
        end
      endcase
    end
  end

  assign tx_data  = ram_dout;
  assign tx_valid = tv_sticky | (ram_cnt == 1);

  // ------------------------------------------------------ reference model
  logic [7:0] m_mem [256];
  logic [7:0] m_wa = '0;
  logic [7:0] m_ra = '0;
  bit         m_rd_seen = 1'b0;

  typedef struct { int cyc; logic [9:0] data; } rx_exp_t;
  typedef struct { int cyc; logic [7:0] val; int n; } tx_exp_t;

  rx_exp_t exp_rx[$];
  tx_exp_t exp_tx[$];
  int      exp_fe[$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // ------------------------------------------------------------- monitor
  always @(negedge clk) begin
    logic ev;
    logic eb;
    int   k;
    if (cyc > 0) begin
      ev = (exp_rx.size() > 0) && (exp_rx[0].cyc == cyc);
      chk("rx_valid", rx_valid, ev);
      if (ev) begin
        chk("rx_data", rx_data, exp_rx[0].data);
        void'(exp_rx.pop_front());
      end

      eb = 1'b0;
      if ((exp_tx.size() > 0) && (cyc >= exp_tx[0].cyc)) begin
        k  = cyc - exp_tx[0].cyc;
        eb = exp_tx[0].val[7-k];
        if (k == exp_tx[0].n - 1) void'(exp_tx.pop_front());
      end
      chk("miso", MISO, eb);

`ifdef SPI_FRAME_ERR_EN
      ev = (exp_fe.size() > 0) && (exp_fe[0] == cyc);
      chk("frame_err", frame_err, ev);
      if (ev) void'(exp_fe.pop_front());
`endif
    end
  end

  // One frame: nb bits sent (10 = complete), hold extra cycles of SS_n low,
  // RAM delay dly, sticky tx_valid, and optional reset rst_off cycles after
  // the expected MISO capture. Called just after a negedge with SS_n high.
  task automatic run_frame(input logic [1:0] cmd, input logic [7:0] pl, input int nb,
                           input int hold, input int dly, input bit sticky, input int rst_off);
    logic [9:0] fw;
    int c0, c_end, cap, stop, n, rst_p, k;
    bit rd_path;
    rx_exp_t rx_e;
    tx_exp_t tx_e;

    tv_sticky = sticky;
    ram_delay = dly;
    c0      = cyc + 1;
    fw      = {cmd, pl};
    rd_path = cmd[1] && m_rd_seen;
    c_end   = (nb == 10) ? (c0 + 11 + hold) : (c0 + 1 + nb);
    rst_p   = 0;

    if (nb == 10) begin
      rx_e.cyc = c0 + 10; rx_e.data = fw;
      exp_rx.push_back(rx_e);
      case (cmd)
        2'b00: m_wa = pl;
        2'b01: m_mem[m_wa] = pl;
        2'b10: m_ra = pl;
        default: ;
      endcase
      if (cmd[1] && !rd_path) m_rd_seen = 1'b1;
      if (rd_path) begin
        cap  = c0 + 12 + (sticky ? 0 : dly);
        stop = c_end;
        if (rst_off >= 0) begin
          rst_p = cap + rst_off;
          stop  = rst_p;
        end
        if (cap < stop) begin
          n = (stop - cap >= 8) ? 8 : (stop - cap);
          tx_e.cyc = cap; tx_e.val = m_mem[m_ra]; tx_e.n = n;
          exp_tx.push_back(tx_e);
          if (n == 8) m_rd_seen = 1'b0;
          else if (rst_p == 0) exp_fe.push_back(c_end);
        end
      end
    end else if (nb > 0) begin
      exp_fe.push_back(c_end);
    end
    if (rst_p != 0) m_rd_seen = 1'b0;

    SS_n = 1'b0;
    MOSI = 1'($urandom);
    for (int p = c0 + 1; p < c_end; p++) begin
      @(negedge clk);
      if (p == rst_p) begin
        rst  = 1'b1;
        SS_n = 1'b1;
        break;
      end
      k    = p - c0 - 1;
      MOSI = (k < 10) ? fw[9-k] : 1'($urandom);
    end
    @(negedge clk);
    rst  = 1'b0;
    SS_n = 1'b1;
    MOSI = 1'($urandom);
    repeat ($urandom_range(1, 3)) @(negedge clk);
  endtask

  // -------------------------------------------------------------- stimulus
  initial begin
    logic [1:0] cmd;
    int nb;
    rst  = 1'b1;
    SS_n = 1'b1;
    MOSI = 1'b0;
    for (int i = 0; i < 256; i++) m_mem[i] = 8'(i) ^ 8'h5A;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    run_frame(2'b00, 8'h3C, 10, 2, 0, 1'b0, -1);              // write address
    run_frame(2'b01, 8'hA5, 10, 0, 0, 1'b0, -1);              // write data
    run_frame(2'b10, 8'h3C, 10, 1, 0, 1'b0, -1);              // read address
    run_frame(2'b11, 8'($urandom), 10, 10, 0, 1'b0, -1);      // read data -> A5
    run_frame(2'b00, 8'h11, 5, 0, 0, 1'b0, -1);               // abort after 5 bits
    run_frame(2'b10, 8'h3C, 10, 0, 0, 1'b0, -1);
    run_frame(2'b11, 8'($urandom), 10, 12, 0, 1'b0, 3);       // reset mid shift-out
    run_frame(2'b11, 8'h3C, 10, 10, 0, 1'b0, -1);             // must take READ_ADD
    run_frame(2'b11, 8'($urandom), 10, 12, 2, 1'b0, -1);      // slow RAM
    run_frame(2'b10, 8'h07, 10, 0, 0, 1'b0, -1);
    run_frame(2'b11, 8'($urandom), 10, 4, 0, 1'b0, -1);       // shift-out cut short
    run_frame(2'b11, 8'($urandom), 10, 9, 0, 1'b0, -1);       // still READ_DATA
    run_frame(2'b10, 8'h3C, 10, 0, 0, 1'b1, -1);              // tx_valid held high
    run_frame(2'b11, 8'($urandom), 10, 12, 0, 1'b1, -1);
    run_frame(2'b10, 8'h44, 10, 0, 0, 1'b1, -1);
    run_frame(2'b11, 8'($urandom), 10, 12, 0, 1'b1, -1);

    for (int f = 0; f < 40; f++) begin
      if ($urandom_range(0, 9) < 3) cmd = {1'b0, 1'($urandom)};
      else if (m_rd_seen)           cmd = 2'b11;
      else                          cmd = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b10;
      nb = ($urandom_range(0, 5) == 0) ? $urandom_range(0, 9) : 10;
      run_frame(cmd, 8'($urandom), nb, $urandom_range(0, 12), $urandom_range(0, 3),
                ($urandom_range(0, 3) == 0), -1);
    end

    tv_sticky = 1'b0;
    repeat (25) @(negedge clk);
    chk("rx_expect_left", exp_rx.size(), 0);
    chk("miso_expect_left", exp_tx.size(), 0);
`ifdef SPI_FRAME_ERR_EN
    chk("frame_err_expect_left", exp_fe.size(), 0);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "time limit");
  end

endmodule
`default_nettype wire
